// File: rtl/emif_csr_pkg.sv
// Shared register map and STAT field layout for the EMIF control/status block.
package emif_csr_pkg;

    localparam logic [11:0] OFF_DFH     = 12'h000;
    localparam logic [11:0] OFF_STAT    = 12'h008;
    localparam logic [11:0] OFF_CTRL    = 12'h010;
    localparam logic [11:0] OFF_SCRATCH = 12'h018;
    localparam logic [11:0] OFF_ERR_CNT = 12'h020;

    localparam int STAT_SUCC_LSB = 0;
    localparam int STAT_FAIL_LSB = 8;

    // Registers are 64-bit words, so only address bits [11:3] select one.
    function automatic logic [8:0] word_idx(input logic [11:0] off);
        return off[11:3];
    endfunction

endpackage

// File: rtl/emif_rst_pulse.sv
// One channel's reset request pulse: a start reloads the counter, so a
// start during an active pulse extends it rather than stacking a second one.
module emif_rst_pulse
    import emif_csr_pkg::*;
#(
    parameter int RST_PULSE_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic pulse
);

    localparam logic [7:0] LEN = 8'(RST_PULSE_LEN);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LEN;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign pulse = (cnt != 8'd0);

endmodule

// File: rtl/emif_csr.sv
// EMIF CSR block: DFH, calibration status, per-channel reset pulses, scratch.
// Optional ERR_CNT register at 0x20 is built when EMIF_CSR_ERR_CNT_EN is defined.
module emif_csr
    import emif_csr_pkg::*;
#(
    parameter int          NUM_CH        = 4,
    parameter logic [63:0] DFH_VALUE     = 64'h3000000010000009,
    parameter int          RST_PULSE_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       avmm_address,
    input  logic              avmm_read,
    input  logic              avmm_write,
    input  logic [63:0]       avmm_writedata,
    input  logic [7:0]        avmm_byteenable,
    output logic [63:0]       avmm_readdata,
    output logic              avmm_readdatavalid,
    output logic              avmm_waitrequest,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic [NUM_CH-1:0] emif_rst_req
);

    localparam logic [8:0] W_DFH     = word_idx(OFF_DFH);
    localparam logic [8:0] W_STAT    = word_idx(OFF_STAT);
    localparam logic [8:0] W_CTRL    = word_idx(OFF_CTRL);
    localparam logic [8:0] W_SCRATCH = word_idx(OFF_SCRATCH);
`ifdef EMIF_CSR_ERR_CNT_EN
    localparam logic [8:0] W_ERR_CNT = word_idx(OFF_ERR_CNT);
`endif

    logic [8:0]        word;
    logic              unused_addr_bits;
    logic              rd_en;
    logic              wr_en;
    logic [NUM_CH-1:0] succ_m, succ_s, fail_m, fail_s;
    logic [63:0]       scratch;
    logic [63:0]       stat;
    logic [63:0]       ctrl_rd;
    logic [63:0]       rd_data;
    logic [NUM_CH-1:0] ctrl_start;

    assign word             = avmm_address[11:3];
    assign unused_addr_bits = ^avmm_address[2:0];

    // Handshake: a request is taken on any clk edge where its strobe is high
    // and waitrequest is low; read data follows with readdatavalid exactly one
    // cycle later, and readdata is zero in every cycle readdatavalid is low.
    assign rd_en = avmm_read  && !avmm_waitrequest;
    assign wr_en = avmm_write && !avmm_waitrequest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            succ_m <= '0;
            succ_s <= '0;
            fail_m <= '0;
            fail_s <= '0;
        end else begin
            succ_m <= cal_success;
            succ_s <= succ_m;
            fail_m <= cal_fail;
            fail_s <= fail_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch <= '0;
        end else if (wr_en && word == W_SCRATCH) begin
            for (int b = 0; b < 8; b++) begin
                if (avmm_byteenable[b]) scratch[8*b +: 8] <= avmm_writedata[8*b +: 8];
            end
        end
    end

    always_comb begin
        ctrl_start = '0;
        if (wr_en && word == W_CTRL && avmm_byteenable[0]) begin
            ctrl_start = avmm_writedata[NUM_CH-1:0];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        emif_rst_pulse #(.RST_PULSE_LEN(RST_PULSE_LEN)) u_pulse (
            .clk   (clk),
            .rst_n (rst_n),
            .start (ctrl_start[i]),
            .pulse (emif_rst_req[i])
        );
    end

`ifdef EMIF_CSR_ERR_CNT_EN
    logic [NUM_CH-1:0]      fail_q;
    logic [NUM_CH-1:0][7:0] err_cnt;
    logic [63:0]            err_rd;
    logic                   err_clr;

    assign err_clr = wr_en && word == W_ERR_CNT;

    // A clear in the same cycle as a new edge wins; the counts saturate at 0xFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q  <= '0;
            err_cnt <= '0;
        end else begin
            fail_q <= fail_s;
            for (int i = 0; i < NUM_CH; i++) begin
                if (err_clr) begin
                    err_cnt[i] <= 8'd0;
                end else if (fail_s[i] && !fail_q[i] && err_cnt[i] != 8'hFF) begin
                    err_cnt[i] <= err_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        err_rd = '0;
        for (int i = 0; i < NUM_CH; i++) err_rd[8*i +: 8] = err_cnt[i];
    end
`endif

    always_comb begin
        stat                         = '0;
        stat[STAT_SUCC_LSB +: NUM_CH] = succ_s;
        stat[STAT_FAIL_LSB +: NUM_CH] = fail_s;
        ctrl_rd                      = '0;
        ctrl_rd[NUM_CH-1:0]          = emif_rst_req;
    end

    always_comb begin
        rd_data = '0;
        case (word)
            W_DFH:     rd_data = DFH_VALUE;
            W_STAT:    rd_data = stat;
            W_CTRL:    rd_data = ctrl_rd;
            W_SCRATCH: rd_data = scratch;
`ifdef EMIF_CSR_ERR_CNT_EN
            W_ERR_CNT: rd_data = err_rd;
`endif
            default:   rd_data = '0;
        endcase
    end

    // Read data is sampled from the pre-edge registers, so a simultaneous
    // write to the same offset is seen only by the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avmm_waitrequest   <= 1'b1;
            avmm_readdatavalid <= 1'b0;
            avmm_readdata      <= '0;
        end else begin
            avmm_waitrequest   <= 1'b0;
            avmm_readdatavalid <= rd_en;
            avmm_readdata      <= rd_en ? rd_data : 64'd0;
        end
    end

endmodule
